seq_logic_unit: RTL and testbench
=================================

// Module: seq_logic_unit
// PURPOSE
//  Multicycle bitwise logic unit for the ALU: applies AND/OR/XOR/XNOR to two WIDTH-bit operands,
//  CHUNK bits per clock, under a start/done handshake. It is the parametrised, sequential successor
//  of the single-bit gate-level XOR cell. The multicycle control FSM uses it when a full-width
//  combinational logic stage is too costly for the cycle budget.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be a multiple of CHUNK
//  CHUNK   8  bits processed per RUN cycle; NUM_CHUNKS = WIDTH/CHUNK (derived, >=1)
// PORTS
//  clk     in   1      single clock, rising edge
//  rst     in   1      asynchronous, active-high reset
//  start   in   1      request; sampled only in IDLE or DONE
//  op      in   2      00 AND, 01 OR, 10 XOR, 11 XNOR; captured with start
//  a       in   WIDTH  operand A; captured with start
//  b       in   WIDTH  operand B; captured with start
//  busy    out  1      high while in RUN
//  done    out  1      one-cycle pulse; result/zero valid from this cycle
//  result  out  WIDTH  result register
//  zero    out  1      high when the completed result == 0
//  parity  out  1      only with SLU_PARITY_EN: XOR-reduction of the completed result
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, idx=0, busy=0, done=0, result=0, zero=0, parity=0.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE: start=1 -> capture a, b, op; result<=0; idx<=0; go to RUN. start=0 -> stay in IDLE.
//    RUN: result[idx*CHUNK +: CHUNK] <= op(a_q, b_q) slice; idx<=idx+1.
//      At idx==NUM_CHUNKS-1 -> DONE (write the last slice, update zero).
//    DONE: done=1 for exactly this cycle. start=1 -> same capture as in IDLE, go to RUN
//      (back-to-back operation). Otherwise -> IDLE.
//  - Latency: start sampled at edge T0; busy is high for NUM_CHUNKS cycles;
//    done is high in the cycle after edge T0+NUM_CHUNKS. Default parameters: done 5 cycles after start.
//  - Input changes and start are ignored in RUN (no abort, no queueing).
//    Operands are used only from the captured copies a_q/b_q/op_q.
//  - result/zero/parity hold their value after DONE until the next start is accepted.
//    On acceptance result clears to 0, and zero/parity clear to 0.
//  - zero is registered and updated only on the final chunk write: zero = (completed result == 0).
//  - idx width is clog2(NUM_CHUNKS) bits, minimum 1.
//    NUM_CHUNKS==1: RUN lasts 1 cycle and no idx wrap occurs.
//  - Async reset mid-RUN discards the operation. No done is produced for it.
// CONFIGURATION
//  - `define SLU_PARITY_EN: adds the parity port.
//    A running XOR accumulator is cleared on start and XORs each written chunk's reduction.
//    It updates on the final chunk write, so parity is valid at done.
//  - Without the macro: no parity port and no accumulator flop. All other timing is identical.
// STRUCTURE
//  - alu_defs.vh (shared include): op encodings SLU_OP_AND=2'b00, SLU_OP_OR=2'b01,
//    SLU_OP_XOR=2'b10, SLU_OP_XNOR=2'b11, and the FSM state encodings IDLE/RUN/DONE.
//  - One sub-module: logic_slice #(CHUNK) -- combinational (op, a, b) -> y.
//    It is instantiated once and fed by the idx-selected slice of a_q/b_q.
//  - Top level contains the FSM, idx counter, operand capture registers, result and flags.
// TESTING (WIDTH=32, CHUNK=8)
//  1. rst pulse mid-RUN -> busy/done/result/zero go to 0 immediately (async); the FSM idles; no done follows.
//  2. op=XOR, a=32'hFFFF0000, b=32'h0F0F0F0F, start 1 cycle -> busy for 4 cycles;
//     done at cycle 5; result=32'hF0F00F0F; zero=0.
//  3. op=XNOR, a=b=32'h12345678 -> result=32'hFFFFFFFF. op=XOR on the same operands -> result=0, zero=1.
//  4. start on the done cycle with op=AND, a=32'hAAAA5555, b=32'hFFFF00FF -> no IDLE cycle;
//     second done 5 cycles later; result=32'hAAAA0055.
//  5. Hold start=1 and toggle a/b/op during RUN -> result reflects only the captured operands;
//     no restart until DONE.
//  6. SLU_PARITY_EN defined: op=OR, a=32'h00000001, b=32'h00010000 -> result=32'h00010001,
//     parity=0. With b=0 -> parity=1.

Source files
------------

// File: rtl/seq_logic_unit_pkg.sv
// Shared definitions for the multicycle logic unit: op encodings, FSM states, index sizing.
package seq_logic_unit_pkg;

   typedef enum logic [1:0] {
      SLU_OP_AND  = 2'b00,
      SLU_OP_OR   = 2'b01,
      SLU_OP_XOR  = 2'b10,
      SLU_OP_XNOR = 2'b11
   } slu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } slu_state_e;

   // Chunk index needs at least one bit even when there is a single chunk.
   function automatic int unsigned idx_width(input int unsigned num_chunks);
      return (num_chunks > 1) ? $clog2(num_chunks) : 1;
   endfunction

endpackage

// File: rtl/seq_logic_unit_logic_slice.sv
// Combinational CHUNK-bit bitwise operator: y = op(a, b); zero latency, no handshake.
module logic_slice
   import seq_logic_unit_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  slu_op_e          op_i,
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   output logic [CHUNK-1:0] y_o
);

   always_comb begin
      y_o = '0;
      case (op_i)
         SLU_OP_AND:  y_o = a_i & b_i;
         SLU_OP_OR:   y_o = a_i | b_i;
         SLU_OP_XOR:  y_o = a_i ^ b_i;
         SLU_OP_XNOR: y_o = ~(a_i ^ b_i);
         default:     y_o = '0;
      endcase
   end

endmodule

// File: rtl/seq_logic_unit.sv
// Multicycle AND/OR/XOR/XNOR unit, CHUNK bits per cycle; done pulses WIDTH/CHUNK+1 cycles after start.
// start is only taken in IDLE/DONE and ignored while busy; SLU_PARITY_EN adds the parity output.
module seq_logic_unit
   import seq_logic_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
`ifdef SLU_PARITY_EN
   output logic             zero_o,
   output logic             parity_o
`else
   output logic             zero_o
`endif
);

   localparam int NUM_CHUNKS = WIDTH / CHUNK;
   localparam int IDX_W      = idx_width(NUM_CHUNKS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   slu_state_e state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   slu_op_e op_q, op_d;
   // Chunk-major views so the idx-selected slice is a plain array index.
   logic [NUM_CHUNKS-1:0][CHUNK-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
   logic zero_q, zero_d;
   logic [CHUNK-1:0] slice_y;
`ifdef SLU_PARITY_EN
   logic acc_q, acc_d, parity_q, parity_d;
`endif

   logic_slice #(.CHUNK(CHUNK)) u_slice (
      .op_i (op_q),
      .a_i  (a_q[idx_q]),
      .b_i  (b_q[idx_q]),
      .y_o  (slice_y)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         op_q     <= SLU_OP_AND;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
`ifdef SLU_PARITY_EN
         acc_q    <= 1'b0;
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         zero_q   <= zero_d;
`ifdef SLU_PARITY_EN
         acc_q    <= acc_d;
         parity_q <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      zero_d   = zero_q;
`ifdef SLU_PARITY_EN
      acc_d    = acc_q;
      parity_d = parity_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               op_d     = slu_op_e'(op_i);
               a_d      = a_i;
               b_d      = b_i;
               idx_d    = '0;
               result_d = '0;
               zero_d   = 1'b0;
`ifdef SLU_PARITY_EN
               acc_d    = 1'b0;
               parity_d = 1'b0;
`endif
               state_d  = ST_RUN;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_RUN: begin
            result_d[idx_q] = slice_y;
`ifdef SLU_PARITY_EN
            acc_d = acc_q ^ (^slice_y);
`endif
            if (idx_q == LAST_IDX) begin
               // Flags are taken from the fully assembled result, including this last slice.
               zero_d  = (result_d == '0);
`ifdef SLU_PARITY_EN
               parity_d = acc_q ^ (^slice_y);
`endif
               idx_d   = '0;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy_o   = (state_q == ST_RUN);
   assign done_o   = (state_q == ST_DONE);
   assign result_o = result_q;
   assign zero_o   = zero_q;
`ifdef SLU_PARITY_EN
   assign parity_o = parity_q;
`endif

endmodule

// File: tb/tb_seq_logic_unit.sv
// Directed self-checking bench for seq_logic_unit at WIDTH=32, CHUNK=8.
module tb_seq_logic_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;
   logic        zero_o;
`ifdef SLU_PARITY_EN
   logic        parity_o;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   seq_logic_unit #(.WIDTH(32), .CHUNK(8)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (start_i),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o),
`ifdef SLU_PARITY_EN
      .zero_o   (zero_o),
      .parity_o (parity_o)
`else
      .zero_o   (zero_o)
`endif
   );

   // Present a request at the current negedge; returns at the negedge after it was sampled.
   task automatic kick(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      op_i    = op;
      a_i     = a;
      b_i     = b;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   // Returns lat = negedge count (1 = first after acceptance) at which done is seen, -1 on timeout.
   task automatic wait_done(output int lat, output int nbusy);
      lat   = -1;
      nbusy = 0;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
         if (done_o) lat = c;
         else begin
            if (busy_o) nbusy++;
            @(negedge clk_i);
         end
      end
   endtask

   task automatic test_reset;
      #1;
      n_cmp++; if (busy_o !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
      n_cmp++; if (done_o !== 1'b0)   begin n_bad++; $display("FAIL reset_done: got %b expected 0", done_o); end
      n_cmp++; if (result_o !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h expected 0", result_o); end
      n_cmp++; if (zero_o !== 1'b0)   begin n_bad++; $display("FAIL reset_zero: got %b expected 0", zero_o); end
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %b expected 0", busy_o); end
   endtask

   task automatic test_xor;
      int lat, nb;
      kick(2'b10, 32'hFFFF0000, 32'h0F0F0F0F);
      wait_done(lat, nb);
      n_cmp++; if (lat !== 5)   begin n_bad++; $display("FAIL xor_latency: got %0d expected 5", lat); end
      n_cmp++; if (nb !== 4)    begin n_bad++; $display("FAIL xor_busy_cycles: got %0d expected 4", nb); end
      n_cmp++; if (result_o !== 32'hF0F00F0F) begin n_bad++; $display("FAIL xor_result: got %h expected f0f00f0f", result_o); end
      n_cmp++; if (zero_o !== 1'b0) begin n_bad++; $display("FAIL xor_zero: got %b expected 0", zero_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL xor_busy_at_done: got %b expected 0", busy_o); end
      @(negedge clk_i);
      n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL xor_done_pulse: got %b expected 0", done_o); end
      repeat (3) @(negedge clk_i);
      n_cmp++; if (result_o !== 32'hF0F00F0F) begin n_bad++; $display("FAIL xor_result_hold: got %h expected f0f00f0f", result_o); end
   endtask

   task automatic test_xnor_zero;
      int lat, nb;
      kick(2'b11, 32'h12345678, 32'h12345678);
      wait_done(lat, nb);
      n_cmp++; if (result_o !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL xnor_result: got %h expected ffffffff", result_o); end
      n_cmp++; if (zero_o !== 1'b0) begin n_bad++; $display("FAIL xnor_zero: got %b expected 0", zero_o); end
      @(negedge clk_i);
      kick(2'b10, 32'h12345678, 32'h12345678);
      wait_done(lat, nb);
      n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL xor_same_latency: got %0d expected 5", lat); end
      n_cmp++; if (result_o !== 32'h0) begin n_bad++; $display("FAIL xor_same_result: got %h expected 0", result_o); end
      n_cmp++; if (zero_o !== 1'b1) begin n_bad++; $display("FAIL xor_same_zero: got %b expected 1", zero_o); end
      @(negedge clk_i);
   endtask

   task automatic test_back_to_back;
      int lat, nb;
      kick(2'b10, 32'hFFFF0000, 32'h0F0F0F0F);
      wait_done(lat, nb);
      kick(2'b00, 32'hAAAA5555, 32'hFFFF00FF);
      n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL b2b_no_idle: got busy %b expected 1", busy_o); end
      n_cmp++; if (result_o !== 32'h0) begin n_bad++; $display("FAIL b2b_result_clear: got %h expected 0", result_o); end
      wait_done(lat, nb);
      n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 5", lat); end
      n_cmp++; if (result_o !== 32'hAAAA0055) begin n_bad++; $display("FAIL b2b_result: got %h expected aaaa0055", result_o); end
      @(negedge clk_i);
   endtask

   task automatic test_hold_inputs;
      int lat;
      op_i    = 2'b01;
      a_i     = 32'h0000FFFF;
      b_i     = 32'h12340000;
      start_i = 1'b1;
      @(negedge clk_i);
      lat = -1;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
         if (done_o) lat = c;
         else begin
            a_i  = $urandom;
            b_i  = $urandom;
            op_i = op_i + 2'd1;
            @(negedge clk_i);
         end
      end
      start_i = 1'b0;
      n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL hold_latency: got %0d expected 5", lat); end
      n_cmp++; if (result_o !== 32'h1234FFFF) begin n_bad++; $display("FAIL hold_result: got %h expected 1234ffff", result_o); end
      @(negedge clk_i);
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL hold_idle_after: got busy %b expected 0", busy_o); end
   endtask

   task automatic test_reset_mid_run;
      int ndone;
      kick(2'b10, 32'hFFFF0000, 32'h0F0F0F0F);
      @(negedge clk_i);
      @(negedge clk_i);
      n_cmp++; if (result_o !== 32'h00000F0F) begin n_bad++; $display("FAIL midrun_partial: got %h expected 00000f0f", result_o); end
      n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL midrun_busy: got %b expected 1", busy_o); end
      #2 rst_i = 1'b1;
      #1;
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL async_busy: got %b expected 0", busy_o); end
      n_cmp++; if (result_o !== 32'h0) begin n_bad++; $display("FAIL async_result: got %h expected 0", result_o); end
      n_cmp++; if (done_o !== 1'b0 || zero_o !== 1'b0) begin n_bad++; $display("FAIL async_flags: got done %b zero %b expected 0 0", done_o, zero_o); end
      @(negedge clk_i);
      rst_i = 1'b0;
      ndone = 0;
      repeat (10) begin
         @(negedge clk_i);
         if (done_o) ndone++;
      end
      n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL midrun_no_done: got %0d pulses expected 0", ndone); end
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL midrun_idle: got busy %b expected 0", busy_o); end
   endtask

`ifdef SLU_PARITY_EN
   task automatic test_parity;
      int lat, nb;
      kick(2'b01, 32'h00000001, 32'h00010000);
      wait_done(lat, nb);
      n_cmp++; if (result_o !== 32'h00010001) begin n_bad++; $display("FAIL par_result: got %h expected 00010001", result_o); end
      n_cmp++; if (parity_o !== 1'b0) begin n_bad++; $display("FAIL par_even: got %b expected 0", parity_o); end
      @(negedge clk_i);
      kick(2'b01, 32'h00000001, 32'h00000000);
      wait_done(lat, nb);
      n_cmp++; if (result_o !== 32'h00000001) begin n_bad++; $display("FAIL par_result2: got %h expected 00000001", result_o); end
      n_cmp++; if (parity_o !== 1'b1) begin n_bad++; $display("FAIL par_odd: got %b expected 1", parity_o); end
      @(negedge clk_i);
   endtask
`endif

   initial begin
      rst_i   = 1'b1;
      start_i = 1'b0;
      op_i    = 2'b00;
      a_i     = '0;
      b_i     = '0;
      test_reset();
      test_xor();
      test_xnor_zero();
      test_back_to_back();
      test_hold_inputs();
      test_reset_mid_run();
`ifdef SLU_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
